// File: rtl/small_comb_logic_bist_sv.sv
// On-chip stimulus/capture engine for an 8-bit combinational block: LFSR-driven
// vectors, per-vector settle delay, field capture, running statistics and MISR.
module small_comb_logic_bist_sv #(
    parameter int unsigned REPEAT_N = 10,
    parameter int unsigned SETTLE   = 1,
    parameter logic [7:0]  SEED     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  d_in,
    input  logic [7:0]  d_out,
    output logic        busy,
    output logic        done,
    output logic        smp_valid,
    output logic        smp_f,
    output logic        smp_inv,
    output logic [1:0]  smp_xor,
    output logic [1:0]  smp_sum,
    output logic        smp_and,
    output logic        smp_or,
    output logic [7:0]  vec_cnt,
    output logic [7:0]  ones_cnt,
    output logic [15:0] sum_acc,
    output logic [15:0] signature
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // An all-zero seed would lock the LFSR, so it is promoted to 8'h01.
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [3:0] WLAST    = 4'(SETTLE - 1);
    localparam logic [7:0] VLAST    = 8'(REPEAT_N - 1);

    state_t      state, state_nxt;
    logic [7:0]  lfsr;
    logic [3:0]  wcnt;
    logic [7:0]  lfsr_nxt;
    logic [15:0] sig_nxt;
    logic        accept;
    logic        capture;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (wcnt == WLAST) begin
                    capture = 1'b1;
                    if (vec_cnt == VLAST) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy     = (state != IDLE);
        done     = (state == DONE);
        lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        sig_nxt  = {signature[14:0], signature[15] ^ signature[14] ^ signature[12] ^ signature[3]}
                   ^ {8'h00, d_out};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= '0;
            wcnt      <= '0;
            d_in      <= '0;
            smp_valid <= 1'b0;
            smp_f     <= 1'b0;
            smp_inv   <= 1'b0;
            smp_xor   <= '0;
            smp_sum   <= '0;
            smp_and   <= 1'b0;
            smp_or    <= 1'b0;
            vec_cnt   <= '0;
            ones_cnt  <= '0;
            sum_acc   <= '0;
            signature <= '0;
        end else begin
            smp_valid <= capture;
            if (accept) begin
                lfsr      <= SEED_EFF;
                d_in      <= SEED_EFF;
                wcnt      <= '0;
                vec_cnt   <= '0;
                ones_cnt  <= '0;
                sum_acc   <= '0;
                signature <= '0;
            end else if (capture) begin
                smp_f     <= d_out[0];
                smp_inv   <= d_out[1];
                smp_xor   <= d_out[3:2];
                smp_sum   <= d_out[5:4];
                smp_and   <= d_out[6];
                smp_or    <= d_out[7];
                vec_cnt   <= vec_cnt + 8'd1;
                ones_cnt  <= ones_cnt + {7'd0, d_out[0]};
                sum_acc   <= sum_acc + {14'd0, d_out[5:4]};
                signature <= sig_nxt;
                lfsr      <= lfsr_nxt;
                d_in      <= lfsr_nxt;
                wcnt      <= '0;
            end else if (state == RUN) begin
                wcnt <= wcnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_small_comb_logic_bist_sv.sv
// Directed checks of the BIST engine: loopback runs, long settle, zero seed,
// held start, mid-run reset and signature sensitivity.
module tb_small_comb_logic_bist_sv;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: loopback with optional bit flip, REPEAT_N=3, SETTLE=1
    logic        start_a = 1'b0;
    logic [7:0]  flip_a  = 8'h00;
    logic [7:0]  din_a, dout_a;
    logic        busy_a, done_a, sv_a, f_a, inv_a, and_a, or_a;
    logic [1:0]  xor_a, sum_a;
    logic [7:0]  vc_a, oc_a;
    logic [15:0] acc_a, sig_a;
    assign dout_a = din_a ^ flip_a;

    small_comb_logic_bist_sv #(.REPEAT_N(3), .SETTLE(1), .SEED(8'hA5)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .d_in(din_a), .d_out(dout_a),
        .busy(busy_a), .done(done_a), .smp_valid(sv_a), .smp_f(f_a), .smp_inv(inv_a),
        .smp_xor(xor_a), .smp_sum(sum_a), .smp_and(and_a), .smp_or(or_a),
        .vec_cnt(vc_a), .ones_cnt(oc_a), .sum_acc(acc_a), .signature(sig_a)
    );

    // Instance B: d_out tied high, REPEAT_N=2, SETTLE=4
    logic        start_b = 1'b0;
    logic [7:0]  din_b;
    logic        busy_b, done_b, sv_b, f_b, inv_b, and_b, or_b;
    logic [1:0]  xor_b, sum_b;
    logic [7:0]  vc_b, oc_b;
    logic [15:0] acc_b, sig_b;

    small_comb_logic_bist_sv #(.REPEAT_N(2), .SETTLE(4), .SEED(8'hA5)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .d_in(din_b), .d_out(8'hFF),
        .busy(busy_b), .done(done_b), .smp_valid(sv_b), .smp_f(f_b), .smp_inv(inv_b),
        .smp_xor(xor_b), .smp_sum(sum_b), .smp_and(and_b), .smp_or(or_b),
        .vec_cnt(vc_b), .ones_cnt(oc_b), .sum_acc(acc_b), .signature(sig_b)
    );

    // Instance C: zero seed, loopback
    logic        start_c = 1'b0;
    logic [7:0]  din_c;
    logic        busy_c, done_c, sv_c, f_c, inv_c, and_c, or_c;
    logic [1:0]  xor_c, sum_c;
    logic [7:0]  vc_c, oc_c;
    logic [15:0] acc_c, sig_c;

    small_comb_logic_bist_sv #(.REPEAT_N(3), .SETTLE(1), .SEED(8'h00)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .d_in(din_c), .d_out(din_c),
        .busy(busy_c), .done(done_c), .smp_valid(sv_c), .smp_f(f_c), .smp_inv(inv_c),
        .smp_xor(xor_c), .smp_sum(sum_c), .smp_and(and_c), .smp_or(or_c),
        .vec_cnt(vc_c), .ones_cnt(oc_c), .sum_acc(acc_c), .signature(sig_c)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full loopback run on instance A; optional bit flip on the first sample only.
    task automatic run_a(input logic [7:0] flip0, input logic [15:0] exp_sig, input string tag);
        start_a = 1'b1;
        flip_a  = flip0;
        tick();
        start_a = 1'b0;
        check({tag, "_din0"}, din_a, 8'hA5);
        tick();
        flip_a = 8'h00;
        tick();
        tick();
        check({tag, "_done"}, done_a, 1'b1);
        check({tag, "_sig"}, sig_a, exp_sig);
        tick();
        check({tag, "_idle"}, busy_a, 1'b0);
    endtask

    logic [15:0] sig_first;

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_din", din_a, 8'h00);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_vec", vc_a, 8'h00);
        check("rst_sig", sig_a, 16'h0000);
        rst = 1'b0;
        tick();

        // 1: loopback, REPEAT_N=3, SETTLE=1
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("t1_din0", din_a, 8'hA5);
        check("t1_busy", busy_a, 1'b1);
        check("t1_vec0", vc_a, 8'd0);
        tick();
        check("t1_sv1", sv_a, 1'b1);
        check("t1_sum1", sum_a, 2'd2);
        check("t1_din1", din_a, 8'h4A);
        check("t1_done_early", done_a, 1'b0);
        tick();
        check("t1_sum2", sum_a, 2'd0);
        check("t1_din2", din_a, 8'h95);
        check("t1_done_early2", done_a, 1'b0);
        tick();
        check("t1_sum3", sum_a, 2'd1);
        check("t1_done", done_a, 1'b1);
        check("t1_busy_done", busy_a, 1'b1);
        check("t1_vec", vc_a, 8'd3);
        check("t1_acc", acc_a, 16'd3);
        check("t1_ones", oc_a, 8'd2);
        check("t1_sig", sig_a, 16'h0295);
        tick();
        check("t1_done_off", done_a, 1'b0);
        check("t1_busy_off", busy_a, 1'b0);
        check("t1_sv_off", sv_a, 1'b0);
        check("t1_din_hold", din_a, 8'h2A);
        sig_first = sig_a;
        tick();
        check("t1_sig_hold", sig_a, 16'h0295);
        check("t1_vec_hold", vc_a, 8'd3);

        // 6: repeat run gives identical signature; a flipped bit changes it
        run_a(8'h00, 16'h0295, "t6_same");
        check("t6_equal", sig_a, sig_first);
        run_a(8'h01, 16'h0291, "t6_flip");
        check("t6_differs", {15'd0, sig_a != sig_first}, 16'd1);

        // 2: SETTLE=4, d_out=FF, REPEAT_N=2
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("t2_din0", din_b, 8'hA5);
        tick();
        tick();
        tick();
        check("t2_din_held", din_b, 8'hA5);
        check("t2_sv_pre", sv_b, 1'b0);
        tick();
        check("t2_sv1", sv_b, 1'b1);
        check("t2_din1", din_b, 8'h4A);
        check("t2_fields", {f_b, inv_b, xor_b, sum_b, and_b, or_b}, 8'hFF);
        tick();
        check("t2_sv_off", sv_b, 1'b0);
        tick();
        tick();
        check("t2_din1_held", din_b, 8'h4A);
        check("t2_done_early", done_b, 1'b0);
        tick();
        check("t2_sv2", sv_b, 1'b1);
        check("t2_done", done_b, 1'b1);
        check("t2_acc", acc_b, 16'd6);
        check("t2_ones", oc_b, 8'd2);
        check("t2_sig", sig_b, 16'h0100);
        tick();

        // 5: zero seed promoted to 01
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        check("t5_din0", din_c, 8'h01);
        tick();
        check("t5_din1", din_c, 8'h02);
        check("t5_f", f_c, 1'b1);
        tick();
        tick();
        check("t5_done", done_c, 1'b1);
        tick();

        // 4: start held high through a run
        start_a = 1'b1;
        tick();
        check("t4_din0", din_a, 8'hA5);
        tick();
        tick();
        tick();
        check("t4_done", done_a, 1'b1);
        check("t4_vec", vc_a, 8'd3);
        tick();
        check("t4_idle_gap", busy_a, 1'b0);
        tick();
        check("t4_rearm_busy", busy_a, 1'b1);
        check("t4_rearm_vec", vc_a, 8'd0);
        check("t4_rearm_din", din_a, 8'hA5);
        start_a = 1'b0;
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        check("t4_done2", done_a, 1'b1);
        check("t4_vec2", vc_a, 8'd3);
        tick();

        // 3: reset mid-run after the first sample
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        check("t3_first_sample", vc_a, 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t3_din", din_a, 8'h00);
        check("t3_busy", busy_a, 1'b0);
        check("t3_done", done_a, 1'b0);
        check("t3_sv", sv_a, 1'b0);
        check("t3_vec", vc_a, 8'd0);
        check("t3_acc", acc_a, 16'd0);
        check("t3_sig", sig_a, 16'd0);
        check("t3_smp", {f_a, inv_a, xor_a, sum_a, and_a, or_a}, 8'h00);
        tick();
        tick();
        check("t3_no_done", done_a, 1'b0);
        check("t3_still_idle", busy_a, 1'b0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("t3_restart_din", din_a, 8'hA5);
        check("t3_restart_vec", vc_a, 8'd0);
        tick();
        tick();
        tick();
        check("t3_restart_done", done_a, 1'b1);
        check("t3_restart_sig", sig_a, 16'h0295);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
